// File: rtl/gfx_cmd_pkg.sv
// Shared definitions for the graphics command path.
// Used by the serializer and by the command/control unit that consumes its byte stream:
//   - opcode bytes for point and line commands
//   - operand counts per command
//   - FSM state encoding
//   - counter widths
package gfx_cmd_pkg;

    localparam logic [7:0] OP_POINT = 8'd80;
    localparam logic [7:0] OP_LINE  = 8'd76;

    localparam int unsigned POINT_OPERANDS = 3;  // xs, ys, color
    localparam int unsigned LINE_OPERANDS  = 5;  // xs, ys, xe, ye, color

    localparam int unsigned IDX_W = 3;
    localparam int unsigned GAP_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StOpcode,
        StOperand,
        StGap
    } state_e;

endpackage

// File: rtl/gap_timer.sv
// Loadable down-counter with a done flag. It times the idle gap after a command.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; clears the count
//   i_load     load i_load_val into the counter
//   i_load_val gap length in cycles
//   i_en       decrement enable; the count saturates at 0
//   o_done     high during the final gap cycle (count <= 1)
module gap_timer
    import gfx_cmd_pkg::*;
#(
    parameter int unsigned WIDTH = GAP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_done = (r_count <= WIDTH'(1));

endmodule

// File: rtl/cmd_serializer.sv
// Serializes point/line draw requests into a byte stream, one byte per clock.
//   Point stream: 80, xs, ys, color
//   Line stream:  76, xs, ys, xe, ye, color
// Each stream is followed by an idle gap of POINT_GAP or LINE_GAP cycles.
// Ports:
//   clk, rst                         clock; asynchronous active-high reset
//   req_valid / req_ready            request handshake; ready only in IDLE
//   req_op                           0 = point, 1 = line
//   req_xs, req_ys, req_xe, req_ye   draw coordinates
//   req_color                        draw colour
//   cmd / cmd_valid                  registered byte stream
//   busy                             high in every state except IDLE
module cmd_serializer
    import gfx_cmd_pkg::*;
#(
    parameter logic [7:0]  IDLE_BYTE = 8'd0,
    parameter int unsigned POINT_GAP = 2,
    parameter int unsigned LINE_GAP  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_op,
    input  logic [7:0] req_xs,
    input  logic [7:0] req_ys,
    input  logic [7:0] req_xe,
    input  logic [7:0] req_ye,
    input  logic [7:0] req_color,
    output logic [7:0] cmd,
    output logic       cmd_valid,
    output logic       busy
);

    state_e           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_op;
    logic [7:0]       r_xs, r_ys, r_xe, r_ye, r_color;
    logic [7:0]       r_cmd;
    logic             r_cmd_valid;

    logic             w_accept;
    logic [IDX_W-1:0] w_last_idx;
    logic [IDX_W-1:0] w_sel_idx;
    logic [GAP_W-1:0] w_gap_val;
    logic             w_at_last;
    logic             w_gap_load;
    logic             w_gap_done;
    logic [7:0]       w_operand;

    assign req_ready  = (r_state == StIdle);
    assign busy       = (r_state != StIdle);
    assign cmd        = r_cmd;
    assign cmd_valid  = r_cmd_valid;

    assign w_accept   = req_valid && req_ready;
    assign w_last_idx = r_op ? IDX_W'(LINE_OPERANDS - 1) : IDX_W'(POINT_OPERANDS - 1);
    assign w_gap_val  = r_op ? GAP_W'(LINE_GAP) : GAP_W'(POINT_GAP);
    assign w_at_last  = (r_state == StOperand) && (r_idx == w_last_idx);
    assign w_gap_load = w_at_last && (w_gap_val != '0);

    // Index of the operand to drive at the next edge: first operand after the opcode,
    // otherwise the one following the operand currently on cmd.
    assign w_sel_idx  = (r_state == StOpcode) ? '0 : r_idx + IDX_W'(1);

    always_comb begin
        w_operand = r_color;
        if (r_op) begin
            case (w_sel_idx)
                IDX_W'(0): w_operand = r_xs;
                IDX_W'(1): w_operand = r_ys;
                IDX_W'(2): w_operand = r_xe;
                IDX_W'(3): w_operand = r_ye;
                default:   w_operand = r_color;
            endcase
        end else begin
            case (w_sel_idx)
                IDX_W'(0): w_operand = r_xs;
                IDX_W'(1): w_operand = r_ys;
                default:   w_operand = r_color;
            endcase
        end
    end

    gap_timer #(
        .WIDTH (GAP_W)
    ) u_gap_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_gap_load),
        .i_load_val (w_gap_val),
        .i_en       (r_state == StGap),
        .o_done     (w_gap_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_idx       <= '0;
            r_op        <= 1'b0;
            r_xs        <= '0;
            r_ys        <= '0;
            r_xe        <= '0;
            r_ye        <= '0;
            r_color     <= '0;
            r_cmd       <= IDLE_BYTE;
            r_cmd_valid <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_op        <= req_op;
                        r_xs        <= req_xs;
                        r_ys        <= req_ys;
                        r_xe        <= req_xe;
                        r_ye        <= req_ye;
                        r_color     <= req_color;
                        r_cmd       <= req_op ? OP_LINE : OP_POINT;
                        r_cmd_valid <= 1'b1;
                        r_state     <= StOpcode;
                    end
                end
                StOpcode: begin
                    r_idx   <= '0;
                    r_cmd   <= w_operand;
                    r_state <= StOperand;
                end
                StOperand: begin
                    if (w_at_last) begin
                        r_cmd       <= IDLE_BYTE;
                        r_cmd_valid <= 1'b0;
                        // A zero-length gap returns straight to IDLE.
                        r_state     <= (w_gap_val != '0) ? StGap : StIdle;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                        r_cmd <= w_operand;
                    end
                end
                StGap: begin
                    if (w_gap_done) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_serializer.sv
module tb_cmd_serializer;

    localparam logic [7:0] IDLE_B = 8'd0;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_op;
    logic [7:0] req_xs, req_ys, req_xe, req_ye, req_color;
    logic [7:0] cmd;
    logic       cmd_valid;
    logic       busy;

    int vectors    = 0;
    int miscompares = 0;

    cmd_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_xs    (req_xs),
        .req_ys    (req_ys),
        .req_xe    (req_xe),
        .req_ye    (req_ye),
        .req_color (req_color),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not complete within time limit");
        $fatal(1, "timeout");
    end

    // Reference: what the outputs must be k cycles after the accepting edge (k=0 is the
    // opcode cycle). Packed as {cmd_valid, cmd, busy, req_ready}.
    function automatic logic [10:0] exp_at(input logic op, input logic [7:0] xs, input logic [7:0] ys,
                                           input logic [7:0] xe, input logic [7:0] ye,
                                           input logic [7:0] c, input int k);
        logic [7:0] bytes[$];
        int gap;
        bytes = {};
        if (op) begin
            bytes.push_back(8'd76); bytes.push_back(xs); bytes.push_back(ys);
            bytes.push_back(xe);    bytes.push_back(ye); bytes.push_back(c);
            gap = 16;
        end else begin
            bytes.push_back(8'd80); bytes.push_back(xs); bytes.push_back(ys);
            bytes.push_back(c);
            gap = 2;
        end
        if (k < bytes.size())             return {1'b1, bytes[k], 1'b1, 1'b0};
        else if (k < bytes.size() + gap)  return {1'b0, IDLE_B, 1'b1, 1'b0};
        else                              return {1'b0, IDLE_B, 1'b0, 1'b1};
    endfunction

    function automatic int stream_len(input logic op);
        return op ? (6 + 16 + 1) : (4 + 2 + 1);
    endfunction

    function automatic logic [10:0] obs();
        return {cmd_valid, cmd, busy, req_ready};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic op, input logic [7:0] xs, input logic [7:0] ys,
                             input logic [7:0] xe, input logic [7:0] ye, input logic [7:0] c);
        req_valid = 1'b1;
        req_op    = op;
        req_xs    = xs;
        req_ys    = ys;
        req_xe    = xe;
        req_ye    = ye;
        req_color = c;
    endtask

    task automatic test_reset();
        logic [10:0] e;
        rst = 1'b1;
        req_valid = 1'b0;
        drive_req(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        req_valid = 1'b0;
        #2;
        e = {1'b0, IDLE_B, 1'b0, 1'b1};
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL reset_state got %h want %h", obs(), e);
        end
        tick();
        rst = 1'b0;
        tick();
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL post_reset_idle got %h want %h", obs(), e);
        end
    endtask

    task automatic test_point();
        logic [10:0] e;
        drive_req(1'b0, 8'd10, 8'd20, 8'd0, 8'd0, 8'd3);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL point_ready got %b want 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < stream_len(1'b0); k++) begin
            e = exp_at(1'b0, 8'd10, 8'd20, 8'd0, 8'd0, 8'd3, k);
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL point k=%0d got %h want %h", k, obs(), e);
            end
            tick();
        end
    endtask

    task automatic test_line();
        logic [10:0] e;
        drive_req(1'b1, 8'd5, 8'd7, 8'd50, 8'd9, 8'd1);
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < stream_len(1'b1); k++) begin
            e = exp_at(1'b1, 8'd5, 8'd7, 8'd50, 8'd9, 8'd1, k);
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL line k=%0d got %h want %h", k, obs(), e);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] e;
        drive_req(1'b0, 8'd1, 8'd2, 8'd0, 8'd0, 8'd3);
        tick();
        // req_valid stays high; second request presented while the first is in flight.
        for (int k = 0; k < 2 * stream_len(1'b0); k++) begin
            if (k == 0) drive_req(1'b0, 8'd4, 8'd5, 8'd0, 8'd0, 8'd6);
            if (k == 7) req_valid = 1'b0;
            if (k < 7) e = exp_at(1'b0, 8'd1, 8'd2, 8'd0, 8'd0, 8'd3, k);
            else       e = exp_at(1'b0, 8'd4, 8'd5, 8'd0, 8'd0, 8'd6, k - 7);
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL back_to_back k=%0d got %h want %h", k, obs(), e);
            end
            tick();
        end
    endtask

    task automatic test_held_operands();
        logic [10:0] e;
        drive_req(1'b0, 8'd33, 8'd44, 8'd0, 8'd0, 8'd55);
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < stream_len(1'b0); k++) begin
            if (k == 1) begin
                req_xs    = 8'd99;
                req_ys    = 8'd98;
                req_color = 8'd97;
                req_op    = 1'b1;
            end
            e = exp_at(1'b0, 8'd33, 8'd44, 8'd0, 8'd0, 8'd55, k);
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL held_operands k=%0d got %h want %h", k, obs(), e);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_line();
        logic [10:0] e;
        drive_req(1'b1, 8'd5, 8'd7, 8'd50, 8'd9, 8'd1);
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            e = exp_at(1'b1, 8'd5, 8'd7, 8'd50, 8'd9, 8'd1, k);
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL mid_line_pre k=%0d got %h want %h", k, obs(), e);
            end
            if (k < 3) tick();
        end
        // Now in the Xe cycle; reset must take effect without waiting for a clock.
        #2;
        rst = 1'b1;
        #1;
        e = {1'b0, IDLE_B, 1'b0, 1'b1};
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL mid_line_async_reset got %h want %h", obs(), e);
        end
        #1;
        rst = 1'b0;
        tick();
        vectors++;
        if (obs() !== e) begin
            miscompares++;
            $display("FAIL mid_line_after_release got %h want %h", obs(), e);
        end
        drive_req(1'b0, 8'h11, 8'h22, 8'd0, 8'd0, 8'h33);
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < stream_len(1'b0); k++) begin
            e = exp_at(1'b0, 8'h11, 8'h22, 8'd0, 8'd0, 8'h33, k);
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL mid_line_recover k=%0d got %h want %h", k, obs(), e);
            end
            tick();
        end
    endtask

    task automatic test_collision();
        logic [10:0] e;
        drive_req(1'b0, 8'd76, 8'd80, 8'd0, 8'd0, 8'd7);
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < stream_len(1'b0); k++) begin
            e = exp_at(1'b0, 8'd76, 8'd80, 8'd0, 8'd0, 8'd7, k);
            vectors++;
            if (obs() !== e) begin
                miscompares++;
                $display("FAIL collision k=%0d got %h want %h", k, obs(), e);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [10:0] e;
        logic        op;
        logic [7:0]  xs, ys, xe, ye, c;
        for (int n = 0; n < 25; n++) begin
            op = 1'($urandom_range(0, 1));
            xs = 8'($urandom); ys = 8'($urandom); xe = 8'($urandom);
            ye = 8'($urandom); c  = 8'($urandom);
            for (int w = 0; w < int'($urandom_range(0, 3)); w++) tick();
            drive_req(op, xs, ys, xe, ye, c);
            tick();
            req_valid = 1'b0;
            for (int k = 0; k < stream_len(op); k++) begin
                e = exp_at(op, xs, ys, xe, ye, c, k);
                vectors++;
                if (obs() !== e) begin
                    miscompares++;
                    $display("FAIL random n=%0d op=%0d k=%0d got %h want %h", n, op, k, obs(), e);
                end
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_point();
        test_line();
        test_back_to_back();
        test_held_operands();
        test_reset_mid_line();
        test_collision();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
